// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit, one result bit per clock.
// Owns HI/LO and serves the mfhi/mflo/mthi/mtlo moves.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             md_valid,
    input  logic [7:0]       md_op,
    input  logic [WIDTH-1:0] md_rs,
    input  logic [WIDTH-1:0] md_rt,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_rdata,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               done_q, done_d;

    logic               sgn;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fix;
    logic [WIDTH:0]     div_sh, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic               last;

    assign rs_mag = md_rs[WIDTH-1] ? -md_rs : md_rs;
    assign rt_mag = md_rt[WIDTH-1] ? -md_rt : md_rt;

    // acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_fix  = neg_lo_q ? -mul_next : mul_next;

    // acc holds {partial remainder, dividend bits becoming quotient}
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_next = div_diff[WIDTH]
                    ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign div_quo  = div_next[WIDTH-1:0];
    assign div_rem  = div_next[2*WIDTH-1:WIDTH];

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        done_d   = 1'b0;
        sgn      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (md_valid) begin
                    priority case (1'b1)
                        md_op[7], md_op[6]: begin
                            sgn = md_op[7];
                            if (md_rt == '0) begin
                                lo_d   = '1;
                                hi_d   = md_rs;
                                done_d = 1'b1;
                            end else begin
                                state_d  = DIV;
                                cnt_d    = '0;
                                acc_d    = {{WIDTH{1'b0}}, sgn ? rs_mag : md_rs};
                                opb_d    = sgn ? rt_mag : md_rt;
                                neg_lo_d = sgn & (md_rs[WIDTH-1] ^ md_rt[WIDTH-1]);
                                neg_hi_d = sgn & md_rs[WIDTH-1];
                            end
                        end
                        md_op[5], md_op[4]: begin
                            sgn      = md_op[5];
                            state_d  = MUL;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, sgn ? rt_mag : md_rt};
                            opb_d    = sgn ? rs_mag : md_rs;
                            neg_lo_d = sgn & (md_rs[WIDTH-1] ^ md_rt[WIDTH-1]);
                            neg_hi_d = 1'b0;
                        end
                        md_op[3], md_op[2]: begin
                        end
                        md_op[1]: hi_d = md_rs;
                        md_op[0]: lo_d = md_rs;
                        default: begin
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    {hi_d, lo_d} = mul_fix;
                    state_d      = IDLE;
                    cnt_d        = '0;
                    done_d       = 1'b1;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    lo_d    = neg_lo_q ? -div_quo : div_quo;
                    hi_d    = neg_hi_q ? -div_rem : div_rem;
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            done_q   <= done_d;
        end
    end

    assign md_busy  = (state_q != IDLE);
    assign md_done  = done_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign md_rdata = md_op[3] ? hi_q : md_op[2] ? lo_q : '0;

endmodule
